// File: rtl/hazard_flush_ctrl.sv
// hazard_flush_ctrl: load-use, branch, DM-wait and overflow hazard sequencing for the 5-stage core.
// Drives the per-wall flush strobes plus the PC and IF/ID hold strobes.
module hazard_flush_ctrl #(
    parameter int BRANCH_BUBBLES = 2,
    parameter int DM_TIMEOUT     = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] iID_ra_addr,
    input  logic [4:0] iID_rb_addr,
    input  logic       iID_uses_ra,
    input  logic       iID_uses_rb,
    input  logic       iEX_do_dm_read,
    input  logic [4:0] iEX_write_reg_addr,
    input  logic       iEX_branch_taken,
    input  logic       iMEM_dm_access,
    input  logic       iMEM_dm_ready,
    input  logic       iMEM_alu_overflow,
    output logic       do_flush_REG1,
    output logic       do_flush_REG2,
    output logic       do_flush_REG3,
    output logic       do_flush_REG4,
    output logic       oPC_hold,
    output logic       oREG1_hold,
    output logic       oHalted,
    output logic [7:0] oStall_count
);
    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] BRANCH  = 2'd1;
    localparam logic [1:0] DM_WAIT = 2'd2;
    localparam logic [1:0] HALT    = 2'd3;
    localparam logic [1:0] BB_INIT = 2'(BRANCH_BUBBLES - 1);
    localparam logic [7:0] TMO     = 8'(DM_TIMEOUT);

    logic [1:0] state, state_nx, bcnt, bcnt_nx;
    logic [7:0] wcnt, wcnt_nx, wcnt_inc, stall_cnt;
    logic [3:0] flush;
    logic       hold, load_use, dm_stall;

    assign wcnt_inc = wcnt + 8'd1;

    always_comb begin
        load_use = iEX_do_dm_read && iEX_write_reg_addr != 5'd0 &&
                   ((iID_uses_ra && iID_ra_addr == iEX_write_reg_addr) ||
                    (iID_uses_rb && iID_rb_addr == iEX_write_reg_addr));
        dm_stall = iMEM_dm_access && !iMEM_dm_ready;
        state_nx = state;
        bcnt_nx  = '0;
        wcnt_nx  = '0;
        flush    = 4'b0000;
        hold     = 1'b0;
        case (state)
            HALT: begin
                flush = 4'b1111;
                hold  = 1'b1;
            end
            DM_WAIT: begin
                if (iMEM_alu_overflow) begin
                    state_nx = HALT;
                    flush    = 4'b1100;
                    hold     = 1'b1;
                end else if (!iMEM_dm_ready) begin
                    flush    = 4'b0100;
                    hold     = 1'b1;
                    wcnt_nx  = wcnt_inc;
                    state_nx = (wcnt_inc == TMO) ? HALT : DM_WAIT;
                end else begin
                    state_nx = RUN;
                end
            end
            default: begin
                // BRANCH shares the RUN priority chain so overflow and DM wait can preempt it
                if (iMEM_alu_overflow) begin
                    state_nx = HALT;
                    flush    = 4'b1100;
                    hold     = 1'b1;
                end else if (dm_stall) begin
                    flush    = 4'b0100;
                    hold     = 1'b1;
                    wcnt_nx  = 8'd1;
                    state_nx = (TMO == 8'd1) ? HALT : DM_WAIT;
                end else if (state == BRANCH) begin
                    flush    = 4'b0001;
                    bcnt_nx  = bcnt - 2'd1;
                    state_nx = (bcnt == 2'd1) ? RUN : BRANCH;
                end else if (iEX_branch_taken) begin
                    flush = 4'b0011;
                    if (BRANCH_BUBBLES > 1) begin
                        state_nx = BRANCH;
                        bcnt_nx  = BB_INIT;
                    end
                end else if (load_use) begin
                    flush = 4'b0010;
                    hold  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            bcnt      <= '0;
            wcnt      <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nx;
            bcnt      <= bcnt_nx;
            wcnt      <= wcnt_nx;
            stall_cnt <= (hold && stall_cnt != 8'hff) ? stall_cnt + 8'd1 : stall_cnt;
        end
    end

    // Strobes are forced low for the whole time reset is held, not just from the next edge
    assign do_flush_REG1 = reset && flush[0];
    assign do_flush_REG2 = reset && flush[1];
    assign do_flush_REG3 = reset && flush[2];
    assign do_flush_REG4 = reset && flush[3];
    assign oPC_hold      = reset && hold;
    assign oREG1_hold    = reset && hold;
    assign oHalted       = reset && state == HALT;
    assign oStall_count  = stall_cnt;
endmodule

// File: doc/hazard_flush_ctrl.md
# hazard_flush_ctrl

Pipeline hazard and flush controller for the 5-stage core. It generates the per-wall flush strobes (do_flush_REG1..4) that the pipeline register walls sample on posedge and apply on the following negedge, plus PC and IF/ID hold strobes. It detects load-use hazards, taken-branch redirects, data-memory wait states and ALU overflow traps, and sequences the required bubbles with a small state machine.

## Interface
- BRANCH_BUBBLES, 2: number of consecutive cycles REG1 is flushed after a taken branch (1..3).
- DM_TIMEOUT, 15: maximum consecutive cycles spent waiting on iMEM_dm_ready before trapping (1..255).
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- iID_ra_addr  in  5  source register A of the instruction in decode.
- iID_rb_addr  in  5  source register B of the instruction in decode.
- iID_uses_ra  in  1  decode instruction reads ra.
- iID_uses_rb  in  1  decode instruction reads rb.
- iEX_do_dm_read  in  1  the instruction in execute is a load.
- iEX_write_reg_addr  in  5  destination register of the instruction in execute.
- iEX_branch_taken  in  1  the branch in execute resolved taken this cycle.
- iMEM_dm_access  in  1  the instruction in memory stage reads or writes DM.
- iMEM_dm_ready  in  1  DM completes the access this cycle.
- iMEM_alu_overflow  in  1  registered overflow of the instruction in memory stage.
- do_flush_REG1..do_flush_REG4  out  1 each  flush strobes to the register walls.
- oPC_hold  out  1  PC must not advance this cycle.
- oREG1_hold  out  1  IF/ID wall must keep its contents this cycle.
- oHalted  out  1  controller is in HALT.
- oStall_count  out  8  saturating count of stall cycles since reset.

## Operation
- States: RUN, BRANCH, DM_WAIT, HALT. Reset state RUN.
- The load-use hazard is raised when iEX_do_dm_read=1, iEX_write_reg_addr!=0, and either:
  - iID_uses_ra=1 and iID_ra_addr==iEX_write_reg_addr, or
  - iID_uses_rb=1 and iID_rb_addr==iEX_write_reg_addr.
- Register 0 never causes a hazard.
- Priority per cycle, highest first: overflow, DM wait, branch, load-use.
- RUN:
  - If iMEM_alu_overflow=1: go to HALT. This cycle flush REG3 and REG4, hold PC and REG1.
  - Else if iMEM_dm_access=1 and iMEM_dm_ready=0: go to DM_WAIT, load the wait counter with 1. Hold PC and REG1, flush REG3.
  - Else if iEX_branch_taken=1: flush REG1 and REG2. If BRANCH_BUBBLES>1, go to BRANCH with the bubble counter set to BRANCH_BUBBLES-1.
  - Else if load-use: hold PC and REG1, flush REG2 (one bubble). Stay in RUN.
  - Else: all outputs 0.
- BRANCH:
  - Flush REG1 each cycle and decrement the counter. Return to RUN when the counter reaches 0.
  - Overflow or DM wait preempts BRANCH with the RUN rules above.
- DM_WAIT:
  - Hold PC and REG1, flush REG3 every cycle while iMEM_dm_ready=0, incrementing the counter.
  - When iMEM_dm_ready=1: outputs 0 that cycle, go to RUN.
  - When the counter reaches DM_TIMEOUT with ready still 0: go to HALT.
- HALT:
  - All four flushes, oPC_hold, oREG1_hold and oHalted are 1.
  - Only reset exits HALT.
- A branch in the same cycle as a load-use hazard resolves as a branch. The decode instruction is discarded, so no bubble is added.
- oStall_count increments on every cycle with oPC_hold=1 and saturates at 255.

## Timing
- All outputs are combinational from the current state and inputs, and are valid before the posedge that ends the cycle. The walls latch them on that posedge.
- State, counters and oStall_count update on posedge clock.
- Reset (reset=0, asynchronous):
  - State RUN, counters 0, oStall_count 0.
  - Every output 0 while reset is asserted, including the flush strobes.
  - Reset asserted mid-BRANCH, DM_WAIT or HALT aborts immediately. The first cycle after release behaves as RUN.
- Load-use costs exactly 1 stall cycle. The hazard clears once the load leaves execute.
- A taken branch costs BRANCH_BUBBLES flushed fetch slots, counting the resolution cycle.
- DM_WAIT latency equals the number of cycles until ready. Timeout occurs at exactly DM_TIMEOUT not-ready cycles.

## Test plan
- Load to r5 in execute, decode reads ra=r5 with uses_ra=1:
  - Cycle 1: oPC_hold=1, oREG1_hold=1, do_flush_REG2=1, other flushes 0.
  - Next cycle (load gone): all outputs 0, oStall_count=1.
  - Same test with the register address 0: no stall.
- iEX_branch_taken=1 for one cycle, BRANCH_BUBBLES=2:
  - Cycle 1: flush REG1 and REG2.
  - Cycle 2: flush REG1 only.
  - Cycle 3: all 0.
  - With a simultaneous load-use: same sequence, oPC_hold=0.
- dm_access=1 with ready=0 for 3 cycles, then ready=1:
  - oPC_hold=1 and do_flush_REG3=1 for 3 cycles.
  - 4th cycle: all outputs 0, state back to RUN, oStall_count=3.
- DM_TIMEOUT=4, ready held at 0:
  - HALT entered after 4 wait cycles. oHalted=1 and all flushes 1 permanently.
  - reset pulse returns all outputs to 0.
- iMEM_alu_overflow=1 during BRANCH:
  - Same cycle: flush REG3 and REG4, hold PC and REG1.
  - Next cycle: HALT.
- 300 load-use stalls: oStall_count saturates at 255.
